fetcher: RTL
============

Name: fetcher

Overview:
- Instruction-fetch stage, directly upstream of decode.
- Holds the PC and serves instruction words from a direct-mapped instruction cache. On a miss, refills the cache from the memory controller.
- Presents one instruction per cycle to decode, with its PC.
- Redirects on ROB flush (mispredict or jump).

Parameters:
- RESET_PC, 32'h0, PC value after reset.
- ICACHE_INDEX_WIDTH, 6, log2 of icache line count. One 32-bit word per line; 64 lines by default.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rdy  input  1  global enable; when low, all state holds
- out_mem_req  output  1  fetch request to memory controller, held until in_mem_ready
- out_mem_addr  output  32  word-aligned fetch address, stable while out_mem_req=1
- in_mem_ready  input  1  one-cycle pulse: in_mem_instr valid for out_mem_addr
- in_mem_instr  input  32  returned instruction word
- in_stall  input  1  downstream (ROB/RS/LSB) cannot accept an instruction next cycle
- in_rob_flush  input  1  redirect request
- in_rob_target_pc  input  32  redirect target, valid with in_rob_flush
- out_decode_valid  output  1  in_fetcher_instr of decode carries a new instruction this cycle
- out_decode_instr  output  32  instruction word, feeds decode in_fetcher_instr
- out_decode_pc  output  32  PC of out_decode_instr

Behaviour:
- Reset (asynchronous, active-high):
  - pc=RESET_PC, state=IDLE.
  - out_mem_req=0, out_mem_addr=0.
  - out_decode_valid=0, out_decode_instr=0, out_decode_pc=0.
  - All icache valid bits cleared.
- Reset mid-miss abandons the request. A late in_mem_ready arriving after reset is ignored because state=IDLE.
- rdy=0: no register changes, outputs hold, except out_decode_valid, which is forced 0 at the next edge.
- Cache addressing:
  - index = pc[ICACHE_INDEX_WIDTH+1:2]
  - tag = pc[31:ICACHE_INDEX_WIDTH+2]
  - hit = valid[index] && tag match. Lookup is combinational on pc.
- States: IDLE, WAIT_MEM. Priority per edge is flush > memory return > issue.
- IDLE:
  - If in_rob_flush: pc<=in_rob_target_pc, out_decode_valid<=0.
  - Else if hit and !in_stall: out_decode_instr<=line, out_decode_pc<=pc, out_decode_valid<=1, pc<=pc+4 (32-bit wrap).
  - Else if hit and in_stall: out_decode_valid<=0, pc holds.
  - Else (miss): out_mem_req<=1, out_mem_addr<={pc[31:2],2'b00}, state<=WAIT_MEM, out_decode_valid<=0.
- WAIT_MEM:
  - out_mem_req stays 1 and out_mem_addr stays stable. out_decode_valid=0.
  - On in_mem_ready: write line for out_mem_addr (data, tag, valid=1), out_mem_req<=0, state<=IDLE.
  - The line is filled even if a flush occurred meanwhile; the filled address is correct regardless.
  - in_rob_flush in WAIT_MEM: pc<=in_rob_target_pc only; the request completes normally.
  - Flush and in_mem_ready in the same cycle: fill the line, pc<=target, go IDLE.
- Latency:
  - Hit: 1 cycle from pc valid to out_decode_valid. Back-to-back hits issue one instruction per cycle.
  - Miss: memory latency + 1 cycle refill + 1 cycle issue.
- out_decode_valid is a one-cycle pulse per instruction. Decode/ROB consume it unconditionally; in_stall must therefore be asserted one instruction early (e.g. ROB full minus one).
- No branch prediction: sequential pc+4; all redirection comes via in_rob_flush.
- Cache is never invalidated except by reset (no self-modifying code support).
- Misaligned in_rob_target_pc: bits [1:0] are dropped for cache and memory addressing; out_decode_pc reports the value as given.

Decomposition:
- Shared header constant.v:
  - DATA_WIDTH range, ADDR width.
  - TRUE/FALSE, ZERO_DATA.
  - Fetcher state encodings FETCH_IDLE and FETCH_WAIT_MEM.
- Sub-module icache:
  - Ports: clk, rst, index/tag lookup → hit and word; write port (we, addr, data).
  - Arrays: valid bit array (reset to 0), tag array, data array.
- fetcher holds the PC, the state machine, and the output registers.

Test Plan:
- Cold miss: reset, memory returns 32'h00000013 at addr 0 after 3 cycles → out_mem_req high 3 cycles with addr 0; out_decode_valid pulses 2 cycles after in_mem_ready with instr 32'h00000013, pc 0; then out_mem_req for addr 4.
- Hit streaming: preload 0x0–0xC via misses, flush to 0 → four consecutive out_decode_valid cycles with pc 0,4,8,C and no out_mem_req.
- Stall: in_stall=1 for 3 cycles while hitting → out_decode_valid=0 those cycles, pc unchanged, resumes at same pc after release with nothing skipped or duplicated.
- Flush during miss: miss on addr 0x10, flush to 0x0 (cached) before in_mem_ready → request completes and fills 0x10; next issued pc=0x0; a later fetch of 0x10 hits with no memory request.
- Same-cycle flush + in_mem_ready → line filled, pc=target, no spurious out_decode_valid that cycle.
- Conflict eviction: fetch 0x0 then 0x100 (same index, default params) → second fetch misses and replaces the line; refetch 0x0 misses again.
- rdy low 2 cycles mid-stream and async rst mid-WAIT_MEM → state frozen under rdy=0; rst immediately clears out_mem_req and out_decode_valid, pc=RESET_PC, and all icache valid bits are cleared.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction-fetch stage and its icache.
package fetcher_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam word_t ZERO_DATA = '0;

    typedef enum logic {
        FETCH_IDLE     = 1'b0,
        FETCH_WAIT_MEM = 1'b1
    } fetch_state_e;

    function automatic addr_t word_align(input addr_t addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: memory refill handshake, ROB redirect/stall and decode output.
interface fetcher_if;
    import fetcher_pkg::*;

    logic  out_mem_req;
    addr_t out_mem_addr;
    logic  in_mem_ready;
    word_t in_mem_instr;

    logic  in_stall;
    logic  in_rob_flush;
    addr_t in_rob_target_pc;

    logic  out_decode_valid;
    word_t out_decode_instr;
    addr_t out_decode_pc;

    modport master (
        output out_mem_req, out_mem_addr,
        input  in_mem_ready, in_mem_instr,
        input  in_stall, in_rob_flush, in_rob_target_pc,
        output out_decode_valid, out_decode_instr, out_decode_pc
    );

    modport slave (
        input  out_mem_req, out_mem_addr,
        output in_mem_ready, in_mem_instr,
        output in_stall, in_rob_flush, in_rob_target_pc,
        input  out_decode_valid, out_decode_instr, out_decode_pc
    );

endinterface

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache, one word per line; only the valid bits are reset.
module fetcher_icache
    import fetcher_pkg::*;
#(
    parameter  int INDEX_WIDTH = 6,
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   rd_hit,
    output word_t                  rd_word,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  word_t                  wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    word_t                data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = TRUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_word = data_mem[rd_index];

endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: holds the PC, issues cached words to decode and refills misses from memory.
module fetcher
    import fetcher_pkg::*;
#(
    parameter addr_t RESET_PC           = 32'h0,
    parameter int    ICACHE_INDEX_WIDTH = 6
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    fetcher_if.master bus
);

    localparam int TAG_WIDTH = ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2;

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         mem_req_q, mem_req_d;
    addr_t        mem_addr_q, mem_addr_d;
    logic         dec_valid_q, dec_valid_d;
    word_t        dec_instr_q, dec_instr_d;
    addr_t        dec_pc_q, dec_pc_d;

    logic                          cache_hit;
    word_t                         cache_word;
    logic                          fill_en;
    logic [ICACHE_INDEX_WIDTH-1:0] rd_index, wr_index;
    logic [TAG_WIDTH-1:0]          rd_tag, wr_tag;

    // Low PC bits are ignored for lookup so a misaligned redirect still hits its word.
    assign rd_index = pc_q[ICACHE_INDEX_WIDTH+1:2];
    assign rd_tag   = pc_q[ADDR_WIDTH-1:ICACHE_INDEX_WIDTH+2];
    assign wr_index = mem_addr_q[ICACHE_INDEX_WIDTH+1:2];
    assign wr_tag   = mem_addr_q[ADDR_WIDTH-1:ICACHE_INDEX_WIDTH+2];
    assign fill_en  = rdy && (state_q == FETCH_WAIT_MEM) && bus.in_mem_ready;

    fetcher_icache #(
        .INDEX_WIDTH(ICACHE_INDEX_WIDTH)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_index(rd_index),
        .rd_tag  (rd_tag),
        .rd_hit  (cache_hit),
        .rd_word (cache_word),
        .wr_en   (fill_en),
        .wr_index(wr_index),
        .wr_tag  (wr_tag),
        .wr_data (bus.in_mem_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        dec_valid_d = FALSE;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;

        if (rdy) begin
            unique case (state_q)
                FETCH_IDLE: begin
                    if (bus.in_rob_flush) begin
                        pc_d = bus.in_rob_target_pc;
                    end else if (cache_hit) begin
                        if (!bus.in_stall) begin
                            dec_valid_d = TRUE;
                            dec_instr_d = cache_word;
                            dec_pc_d    = pc_q;
                            pc_d        = pc_q + 32'd4;
                        end
                    end else begin
                        mem_req_d  = TRUE;
                        mem_addr_d = word_align(pc_q);
                        state_d    = FETCH_WAIT_MEM;
                    end
                end
                FETCH_WAIT_MEM: begin
                    // A redirect only moves the PC; the outstanding refill still lands.
                    if (bus.in_rob_flush) begin
                        pc_d = bus.in_rob_target_pc;
                    end
                    if (bus.in_mem_ready) begin
                        mem_req_d = FALSE;
                        state_d   = FETCH_IDLE;
                    end
                end
                default: begin
                    state_d = FETCH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            mem_req_q   <= FALSE;
            mem_addr_q  <= '0;
            dec_valid_q <= FALSE;
            dec_instr_q <= ZERO_DATA;
            dec_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    assign bus.out_mem_req      = mem_req_q;
    assign bus.out_mem_addr     = mem_addr_q;
    assign bus.out_decode_valid = dec_valid_q;
    assign bus.out_decode_instr = dec_instr_q;
    assign bus.out_decode_pc    = dec_pc_q;

endmodule
